bus_dest_regs: RTL and testbench
================================

Name: bus_dest_regs

Overview:
- Write-side counterpart of the datapath read bus. Owns the datapath's destination registers: PC, IR, AR, AC, X, Y, Z, STXY, STYZ, STXZ, R, R1, R2, R3.
- Captures the 24-bit bus value into the register chosen by a 5-bit write code and drives all registers out continuously to the bus read mux.
- Writes to instruction/data memory (codes 15/16) go through a req/ack handshake sequenced by a small FSM.

Parameters:
- BUS_WIDTH, 24, width of bus_in.
- ADDR_WIDTH, 16, width of mem_addr.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- bus_in  input  BUS_WIDTH  value currently on the datapath bus
- write_en  input  5  destination code, same numbering as the bus read select
- inc_en  input  5  increment strobes: [0] PC, [1] AR, [2] X, [3] Y, [4] Z
- mem_wr_ack  input  1  memory accepted the write
- pc, ir, ar, r, r3, stxy, styz, stxz  output  16 each  registers
- ac, r2  output  24 each  registers
- x, y, z, r1  output  8 each  registers
- mem_wr_req  output  1  memory write request
- mem_sel  output  1  0 = data memory, 1 = instruction memory
- mem_addr  output  ADDR_WIDTH  write address
- mem_wdata  output  16  write data; DM uses bits [7:0], upper bits 0
- busy  output  1  memory write outstanding
- drop_err  output  1  one-cycle pulse when a memory write code is ignored

Behaviour:
- Reset (rst_n low, asynchronous): every register and output is 0; FSM goes to IDLE. Reset mid-handshake abandons the write; mem_wr_req falls immediately.
- Register write codes, all single-cycle (value visible the cycle after the edge):
  - 1 R, 2 R1, 3 R2, 4 R3, 5 X, 6 Y, 7 Z
  - 8 STXY, 9 STYZ, 10 STXZ, 11 AR, 12 IR, 13 PC, 14 AC
  - Each captures the low N bits of bus_in, where N is the register width; upper bus bits are discarded.
- Codes 0 and 18-31 are no-ops. Code 17 is also a no-op unless the optional feature is enabled.
- Increment: each set inc_en bit adds 1 to its register, modulo the register width (e.g. PC 0xFFFF -> 0x0000, X 0xFF -> 0x00). Several bits may be set together.
- Load and increment on the same register in the same cycle: load wins and the increment is lost.
- Memory write FSM, states IDLE and WAIT_ACK:
  - IDLE, code 15 or 16: latch mem_sel (15 -> 1, 16 -> 0), mem_addr = current AR (value before any same-cycle AR load or increment), and mem_wdata (IM: bus_in[15:0]; DM: {8'h0, bus_in[7:0]}). Go to WAIT_ACK. mem_wr_req and busy go high the next cycle.
  - WAIT_ACK: mem_sel, mem_addr and mem_wdata stay stable. When mem_wr_ack is sampled high, return to IDLE; req and busy drop the following cycle.
  - Back-to-back writes: a new code 15/16 may be accepted in the same cycle the ack is sampled.
  - Code 15/16 arriving in WAIT_ACK without ack: ignored, drop_err pulses for 1 cycle, no state change.
  - mem_wr_ack while IDLE: ignored.
- Register codes and increments are processed normally while busy.

Optional Feature:
- Macro AC_ACCUM_EN.
- Defined: code 17 performs AC <= AC + bus_in[23:0], modulo 2^24, with no carry out. This is the multiply-accumulate step for matrix multiplication. Increments do not apply to AC, so there is no conflict with inc_en.
- Undefined: code 17 is a no-op, and the adder is not synthesized.

Test Plan:
- Write with truncation: bus_in=24'hABCDEF, write_en=2 -> r1=8'hEF next cycle. Then write_en=14 -> ac=24'hABCDEF. Then write_en=13 -> pc=16'hCDEF.
- Increment wrap and priority: pc=16'hFFFF, inc_en=5'b00001 -> pc=0. Then x=8'h10, write_en=5 with bus_in=8'h42 and inc_en[2]=1 together -> x=8'h42.
- DM handshake: ar=16'h0100, bus_in=24'h000077, write_en=16 -> next cycle mem_wr_req=1, mem_sel=0, mem_addr=16'h0100, mem_wdata=16'h0077. Hold ack low 3 cycles (req stays high), then ack=1 -> req=0 and busy=0 the following cycle.
- Collision: during WAIT_ACK apply write_en=15 -> drop_err pulses for 1 cycle and the outstanding fields are unchanged. In the same cycle write_en=6 with bus_in=8'h05 -> y=8'h05.
- Reset mid-op: assert rst_n=0 asynchronously while busy -> mem_wr_req, busy and all registers read 0 before the next clock edge.
- With AC_ACCUM_EN defined: ac=24'hFFFFF0, write_en=17, bus_in=24'h000020 -> ac=24'h000010. Without the macro the same stimulus leaves ac unchanged.

Source files
------------

// File: rtl/bus_dest_regs_if.sv
// Memory-write handshake bundle between bus_dest_regs and the instruction/data memory.
// The design drives the request side through the master modport.
interface bus_dest_regs_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  mem_wr_req;
    logic                  mem_sel;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [15:0]           mem_wdata;
    logic                  mem_wr_ack;

    modport master (
        output mem_wr_req,
        output mem_sel,
        output mem_addr,
        output mem_wdata,
        input  mem_wr_ack
    );

    modport slave (
        input  mem_wr_req,
        input  mem_sel,
        input  mem_addr,
        input  mem_wdata,
        output mem_wr_ack
    );
endinterface

// File: rtl/bus_dest_regs.sv
// Destination registers of the datapath bus plus the memory-write request FSM.
// Optional macro AC_ACCUM_EN: write code 17 accumulates bus_in into AC.
module bus_dest_regs #(
    parameter int BUS_WIDTH  = 24,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BUS_WIDTH-1:0] bus_in,
    input  logic [4:0]           write_en,
    input  logic [4:0]           inc_en,
    bus_dest_regs_if.master      mem,
    output logic [15:0]          pc,
    output logic [15:0]          ir,
    output logic [15:0]          ar,
    output logic [15:0]          r,
    output logic [15:0]          r3,
    output logic [15:0]          stxy,
    output logic [15:0]          styz,
    output logic [15:0]          stxz,
    output logic [23:0]          ac,
    output logic [23:0]          r2,
    output logic [7:0]           x,
    output logic [7:0]           y,
    output logic [7:0]           z,
    output logic [7:0]           r1,
    output logic                 busy,
    output logic                 drop_err
);

    localparam logic [4:0] CODE_R    = 5'd1;
    localparam logic [4:0] CODE_R1   = 5'd2;
    localparam logic [4:0] CODE_R2   = 5'd3;
    localparam logic [4:0] CODE_R3   = 5'd4;
    localparam logic [4:0] CODE_X    = 5'd5;
    localparam logic [4:0] CODE_Y    = 5'd6;
    localparam logic [4:0] CODE_Z    = 5'd7;
    localparam logic [4:0] CODE_STXY = 5'd8;
    localparam logic [4:0] CODE_STYZ = 5'd9;
    localparam logic [4:0] CODE_STXZ = 5'd10;
    localparam logic [4:0] CODE_AR   = 5'd11;
    localparam logic [4:0] CODE_IR   = 5'd12;
    localparam logic [4:0] CODE_PC   = 5'd13;
    localparam logic [4:0] CODE_AC   = 5'd14;
    localparam logic [4:0] CODE_IM   = 5'd15;
    localparam logic [4:0] CODE_DM   = 5'd16;
`ifdef AC_ACCUM_EN
    localparam logic [4:0] CODE_ACC  = 5'd17;
`endif

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_WAIT_ACK = 1'b1
    } state_t;

    logic [15:0]           pc_r, ir_r, ar_r, r_r, r3_r, stxy_r, styz_r, stxz_r;
    logic [23:0]           ac_r, r2_r;
    logic [7:0]            x_r, y_r, z_r, r1_r;
    state_t                state_r, next_state_s;
    logic                  accept_s, drop_s, mem_code_s;
    logic                  req_r, busy_r, drop_r, sel_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [15:0]           wdata_r;

    // Register loads and increments; a load on a register suppresses its increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r   <= 16'h0000;
            ir_r   <= 16'h0000;
            ar_r   <= 16'h0000;
            r_r    <= 16'h0000;
            r3_r   <= 16'h0000;
            stxy_r <= 16'h0000;
            styz_r <= 16'h0000;
            stxz_r <= 16'h0000;
            ac_r   <= 24'h000000;
            r2_r   <= 24'h000000;
            x_r    <= 8'h00;
            y_r    <= 8'h00;
            z_r    <= 8'h00;
            r1_r   <= 8'h00;
        end else begin
            if (inc_en[0] && (write_en != CODE_PC)) pc_r <= pc_r + 16'd1;
            else                                    pc_r <= pc_r;
            if (inc_en[1] && (write_en != CODE_AR)) ar_r <= ar_r + 16'd1;
            else                                    ar_r <= ar_r;
            if (inc_en[2] && (write_en != CODE_X))  x_r  <= x_r + 8'd1;
            else                                    x_r  <= x_r;
            if (inc_en[3] && (write_en != CODE_Y))  y_r  <= y_r + 8'd1;
            else                                    y_r  <= y_r;
            if (inc_en[4] && (write_en != CODE_Z))  z_r  <= z_r + 8'd1;
            else                                    z_r  <= z_r;

            case (write_en)
                CODE_R:    r_r    <= bus_in[15:0];
                CODE_R1:   r1_r   <= bus_in[7:0];
                CODE_R2:   r2_r   <= bus_in[23:0];
                CODE_R3:   r3_r   <= bus_in[15:0];
                CODE_X:    x_r    <= bus_in[7:0];
                CODE_Y:    y_r    <= bus_in[7:0];
                CODE_Z:    z_r    <= bus_in[7:0];
                CODE_STXY: stxy_r <= bus_in[15:0];
                CODE_STYZ: styz_r <= bus_in[15:0];
                CODE_STXZ: stxz_r <= bus_in[15:0];
                CODE_AR:   ar_r   <= bus_in[15:0];
                CODE_IR:   ir_r   <= bus_in[15:0];
                CODE_PC:   pc_r   <= bus_in[15:0];
                CODE_AC:   ac_r   <= bus_in[23:0];
`ifdef AC_ACCUM_EN
                CODE_ACC:  ac_r   <= ac_r + bus_in[23:0];
`endif
                default:   ;
            endcase
        end
    end

    assign mem_code_s = (write_en == CODE_IM) || (write_en == CODE_DM);

    // Next-state logic; an ack frees the slot so a new write can be taken in the same cycle.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        drop_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (mem_code_s) begin
                    accept_s     = 1'b1;
                    next_state_s = ST_WAIT_ACK;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WAIT_ACK: begin
                if (mem.mem_wr_ack) begin
                    accept_s     = mem_code_s;
                    next_state_s = mem_code_s ? ST_WAIT_ACK : ST_IDLE;
                end else if (mem_code_s) begin
                    drop_s       = 1'b1;
                    next_state_s = ST_WAIT_ACK;
                end else begin
                    next_state_s = ST_WAIT_ACK;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // FSM state and registered handshake outputs; fields are held until the next accepted write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            req_r   <= 1'b0;
            busy_r  <= 1'b0;
            drop_r  <= 1'b0;
            sel_r   <= 1'b0;
            addr_r  <= {ADDR_WIDTH{1'b0}};
            wdata_r <= 16'h0000;
        end else begin
            state_r <= next_state_s;
            req_r   <= (next_state_s == ST_WAIT_ACK);
            busy_r  <= (next_state_s == ST_WAIT_ACK);
            drop_r  <= drop_s;
            if (accept_s) begin
                sel_r   <= (write_en == CODE_IM);
                addr_r  <= ADDR_WIDTH'(ar_r);
                wdata_r <= (write_en == CODE_IM) ? bus_in[15:0] : {8'h00, bus_in[7:0]};
            end else begin
                sel_r   <= sel_r;
                addr_r  <= addr_r;
                wdata_r <= wdata_r;
            end
        end
    end

    assign pc   = pc_r;
    assign ir   = ir_r;
    assign ar   = ar_r;
    assign r    = r_r;
    assign r3   = r3_r;
    assign stxy = stxy_r;
    assign styz = styz_r;
    assign stxz = stxz_r;
    assign ac   = ac_r;
    assign r2   = r2_r;
    assign x    = x_r;
    assign y    = y_r;
    assign z    = z_r;
    assign r1   = r1_r;

    assign mem.mem_wr_req = req_r;
    assign mem.mem_sel    = sel_r;
    assign mem.mem_addr   = addr_r;
    assign mem.mem_wdata  = wdata_r;
    assign busy           = busy_r;
    assign drop_err       = drop_r;

endmodule

// File: tb/tb_bus_dest_regs.sv
// Randomized and directed bench for bus_dest_regs against a code-indexed register model.
module tb_bus_dest_regs;

    logic        clk;
    logic        rst_n;
    logic [23:0] bus_in;
    logic [4:0]  write_en;
    logic [4:0]  inc_en;
    logic [15:0] pc, ir, ar, r, r3, stxy, styz, stxz;
    logic [23:0] ac, r2;
    logic [7:0]  x, y, z, r1;
    logic        busy, drop_err;

    int checks = 0;
    int errors = 0;

    bus_dest_regs_if #(.ADDR_WIDTH(16)) mem_if ();

    bus_dest_regs #(.BUS_WIDTH(24), .ADDR_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus_in(bus_in), .write_en(write_en), .inc_en(inc_en),
        .mem(mem_if.master),
        .pc(pc), .ir(ir), .ar(ar), .r(r), .r3(r3), .stxy(stxy), .styz(styz), .stxz(stxz),
        .ac(ac), .r2(r2), .x(x), .y(y), .z(z), .r1(r1), .busy(busy), .drop_err(drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: registers indexed by their write code.
    logic [23:0] m_reg [1:14];
    logic        m_busy, m_sel, m_drop;
    logic [15:0] m_addr, m_wdata;

    function automatic int wid(int c);
        case (c)
            2, 5, 6, 7: return 8;
            3, 14:      return 24;
            default:    return 16;
        endcase
    endfunction

    function automatic logic [23:0] wrap(longint v, int c);
        longint m;
        m = (64'sd1 <<< wid(c)) - 64'sd1;
        return 24'(v & m);
    endfunction

    function automatic logic [23:0] dut_reg(int c);
        case (c)
            1: return {8'h00, r};     2: return {16'h0000, r1};
            3: return r2;             4: return {8'h00, r3};
            5: return {16'h0000, x};  6: return {16'h0000, y};
            7: return {16'h0000, z};  8: return {8'h00, stxy};
            9: return {8'h00, styz};  10: return {8'h00, stxz};
            11: return {8'h00, ar};   12: return {8'h00, ir};
            13: return {8'h00, pc};   default: return ac;
        endcase
    endfunction

    task automatic model_reset();
        for (int c = 1; c <= 14; c++) m_reg[c] = 24'h0;
        m_busy = 1'b0; m_sel = 1'b0; m_drop = 1'b0; m_addr = 16'h0; m_wdata = 16'h0;
    endtask

    task automatic model_update();
        logic [23:0] nxt [1:14];
        int inc_code [0:4];
        int we;
        logic ack;
        inc_code = '{13, 11, 5, 6, 7};
        we  = int'(write_en);
        ack = mem_if.mem_wr_ack;
        for (int c = 1; c <= 14; c++) nxt[c] = m_reg[c];
        for (int b = 0; b < 5; b++)
            if (inc_en[b]) nxt[inc_code[b]] = wrap(longint'(m_reg[inc_code[b]]) + 1, inc_code[b]);
        if (we >= 1 && we <= 14) nxt[we] = wrap(longint'(bus_in), we);
`ifdef AC_ACCUM_EN
        if (we == 17) nxt[14] = wrap(longint'(m_reg[14]) + longint'(bus_in), 14);
`endif
        m_drop = 1'b0;
        if ((we == 15 || we == 16) && (!m_busy || ack)) begin
            m_busy  = 1'b1;
            m_sel   = (we == 15);
            m_addr  = m_reg[11][15:0];
            m_wdata = (we == 15) ? bus_in[15:0] : {8'h00, bus_in[7:0]};
        end else if (m_busy && ack) begin
            m_busy = 1'b0;
        end else if (m_busy && (we == 15 || we == 16)) begin
            m_drop = 1'b1;
        end
        for (int c = 1; c <= 14; c++) m_reg[c] = nxt[c];
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive(input logic [4:0] we, input logic [23:0] bus, input logic [4:0] inc,
                         input logic ack);
        write_en = we; bus_in = bus; inc_en = inc; mem_if.mem_wr_ack = ack;
    endtask

    task automatic test_reset();
        drive(5'd0, 24'h0, 5'd0, 1'b0);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #4 rst_n = 1'b1;
        cycle();
        for (int c = 1; c <= 14; c++) begin
            checks++;
            if (dut_reg(c) !== 24'h0) begin
                errors++; $display("FAIL reset_reg%0d got %h exp 000000", c, dut_reg(c));
            end
        end
        checks++;
        if ({mem_if.mem_wr_req, busy, drop_err, mem_if.mem_addr} !== 19'h0) begin
            errors++; $display("FAIL reset_mem got %b%b%b %h exp 0", mem_if.mem_wr_req, busy,
                               drop_err, mem_if.mem_addr);
        end
    endtask

    task automatic test_truncation();
        drive(5'd2, 24'hABCDEF, 5'd0, 1'b0); cycle();
        checks++; if (r1 !== 8'hEF) begin errors++; $display("FAIL trunc_r1 got %h exp EF", r1); end
        drive(5'd14, 24'hABCDEF, 5'd0, 1'b0); cycle();
        checks++; if (ac !== 24'hABCDEF) begin errors++; $display("FAIL trunc_ac got %h exp ABCDEF", ac); end
        drive(5'd13, 24'hABCDEF, 5'd0, 1'b0); cycle();
        checks++; if (pc !== 16'hCDEF) begin errors++; $display("FAIL trunc_pc got %h exp CDEF", pc); end
    endtask

    task automatic test_inc_priority();
        drive(5'd13, 24'h00FFFF, 5'd0, 1'b0); cycle();
        drive(5'd0, 24'h0, 5'b00001, 1'b0); cycle();
        checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL inc_pc_wrap got %h exp 0000", pc); end
        drive(5'd7, 24'h0000FF, 5'd0, 1'b0); cycle();
        drive(5'd0, 24'h0, 5'b11110, 1'b0); cycle();
        checks++;
        if ({z, ar} !== {8'h00, m_reg[11][15:0]}) begin
            errors++; $display("FAIL inc_multi got z=%h ar=%h exp z=00 ar=%h", z, ar, m_reg[11][15:0]);
        end
        drive(5'd5, 24'h000010, 5'd0, 1'b0); cycle();
        drive(5'd5, 24'h000042, 5'b00100, 1'b0); cycle();
        checks++; if (x !== 8'h42) begin errors++; $display("FAIL load_beats_inc got %h exp 42", x); end
    endtask

    task automatic test_dm_handshake();
        drive(5'd11, 24'h000100, 5'd0, 1'b0); cycle();
        drive(5'd16, 24'h000077, 5'd0, 1'b0); cycle();
        checks++;
        if ({mem_if.mem_wr_req, busy, mem_if.mem_sel, mem_if.mem_addr, mem_if.mem_wdata}
            !== {1'b1, 1'b1, 1'b0, 16'h0100, 16'h0077}) begin
            errors++; $display("FAIL dm_req got req=%b sel=%b addr=%h wd=%h exp 1 0 0100 0077",
                               mem_if.mem_wr_req, mem_if.mem_sel, mem_if.mem_addr, mem_if.mem_wdata);
        end
        drive(5'd0, 24'h0, 5'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (mem_if.mem_wr_req !== 1'b1) begin
                errors++; $display("FAIL dm_hold%0d got %b exp 1", i, mem_if.mem_wr_req);
            end
        end
        drive(5'd0, 24'h0, 5'd0, 1'b1); cycle();
        checks++;
        if ({mem_if.mem_wr_req, busy} !== 2'b00) begin
            errors++; $display("FAIL dm_ack got req=%b busy=%b exp 0 0", mem_if.mem_wr_req, busy);
        end
    endtask

    task automatic test_collision_back_to_back();
        drive(5'd15, 24'h00ABCD, 5'd0, 1'b0); cycle();
        drive(5'd15, 24'h001111, 5'd0, 1'b0); cycle();
        checks++;
        if ({drop_err, mem_if.mem_sel, mem_if.mem_addr, mem_if.mem_wdata}
            !== {1'b1, 1'b1, 16'h0100, 16'hABCD}) begin
            errors++; $display("FAIL collide got drop=%b sel=%b addr=%h wd=%h exp 1 1 0100 ABCD",
                               drop_err, mem_if.mem_sel, mem_if.mem_addr, mem_if.mem_wdata);
        end
        drive(5'd6, 24'h000005, 5'd0, 1'b0); cycle();
        checks++;
        if ({drop_err, busy, y} !== {1'b0, 1'b1, 8'h05}) begin
            errors++; $display("FAIL busy_write got drop=%b busy=%b y=%h exp 0 1 05", drop_err, busy, y);
        end
        drive(5'd16, 24'h1234EE, 5'd0, 1'b1); cycle();
        checks++;
        if ({mem_if.mem_wr_req, mem_if.mem_sel, mem_if.mem_wdata, drop_err}
            !== {1'b1, 1'b0, 16'h00EE, 1'b0}) begin
            errors++; $display("FAIL b2b got req=%b sel=%b wd=%h drop=%b exp 1 0 00EE 0",
                               mem_if.mem_wr_req, mem_if.mem_sel, mem_if.mem_wdata, drop_err);
        end
        drive(5'd0, 24'h0, 5'd0, 1'b1); cycle();
        drive(5'd0, 24'h0, 5'd0, 1'b1); cycle();
        checks++;
        if ({mem_if.mem_wr_req, busy, drop_err} !== 3'b000) begin
            errors++; $display("FAIL ack_idle got req=%b busy=%b drop=%b exp 000",
                               mem_if.mem_wr_req, busy, drop_err);
        end
    endtask

    task automatic test_accum();
        logic [23:0] exp_ac;
        drive(5'd14, 24'hFFFFF0, 5'd0, 1'b0); cycle();
        drive(5'd17, 24'h000020, 5'd0, 1'b0); cycle();
`ifdef AC_ACCUM_EN
        exp_ac = 24'h000010;
`else
        exp_ac = 24'hFFFFF0;
`endif
        checks++; if (ac !== exp_ac) begin errors++; $display("FAIL accum got %h exp %h", ac, exp_ac); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            drive(5'($urandom_range(0, 31)), 24'($urandom), 5'($urandom_range(0, 31)) & 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 3) == 0));
            cycle();
            for (int c = 1; c <= 14; c++) begin
                checks++;
                if (dut_reg(c) !== m_reg[c]) begin
                    errors++; $display("FAIL rand_reg%0d step %0d got %h exp %h", c, n, dut_reg(c), m_reg[c]);
                end
            end
            checks++;
            if ({mem_if.mem_wr_req, busy, drop_err} !== {m_busy, m_busy, m_drop}) begin
                errors++; $display("FAIL rand_ctl step %0d got %b%b%b exp %b%b%b", n,
                                   mem_if.mem_wr_req, busy, drop_err, m_busy, m_busy, m_drop);
            end
            if (m_busy) begin
                checks++;
                if ({mem_if.mem_sel, mem_if.mem_addr, mem_if.mem_wdata} !== {m_sel, m_addr, m_wdata}) begin
                    errors++; $display("FAIL rand_fields step %0d got %b %h %h exp %b %h %h", n,
                                       mem_if.mem_sel, mem_if.mem_addr, mem_if.mem_wdata, m_sel, m_addr, m_wdata);
                end
            end
        end
    endtask

    task automatic test_reset_midop();
        drive(5'd15, 24'h000042, 5'd0, 1'b0); cycle();
        drive(5'd0, 24'h0, 5'd0, 1'b0);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL midop_busy got %b exp 1", busy); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_if.mem_wr_req, busy} !== 2'b00) begin
            errors++; $display("FAIL midop_rst got req=%b busy=%b exp 0 0", mem_if.mem_wr_req, busy);
        end
        for (int c = 1; c <= 14; c++) begin
            checks++;
            if (dut_reg(c) !== 24'h0) begin
                errors++; $display("FAIL midop_reg%0d got %h exp 000000", c, dut_reg(c));
            end
        end
        model_reset();
        #2 rst_n = 1'b1;
        cycle();
        checks++;
        if (mem_if.mem_wr_req !== 1'b0) begin
            errors++; $display("FAIL post_rst_req got %b exp 0", mem_if.mem_wr_req);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        drive(5'd0, 24'h0, 5'd0, 1'b0);
        test_reset();
        test_truncation();
        test_inc_priority();
        test_dm_handshake();
        test_collision_back_to_back();
        test_accum();
        test_random();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
